// File: rtl/apb_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// apb_ctrl_pkg
// Shared definitions for the two-requester APB arbiter:
//   - one-hot FSM state encoding (4 bits)
//   - default ADDR_W / DATA_W / TIMEOUT values
//   - bridge direction constants (DIR_READ / DIR_WRITE)
//   - idx2oh: requester index to one-hot grant vector
// -----------------------------------------------------------------------------
package apb_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SETUP  = 4'b0010,
    ST_ACCESS = 4'b0100,
    ST_DONE   = 4'b1000
  } state_e;

  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 16;

  localparam logic DIR_READ  = 1'b1;
  localparam logic DIR_WRITE = 1'b0;

  function automatic logic [1:0] idx2oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter_if
// Bundles the requester-side handshake and the APB bridge/bus signals of the
// arbiter.
//   slave  modport : the arbiter's view (requests and bus monitors in,
//                    acks/done/bridge controls out)
//   master modport : the environment's view (requesters + bridge/bus model)
// Requester i uses bit i of req_valid/req_write/req_ack/req_done and slice i
// of req_addr/req_wdata.
// -----------------------------------------------------------------------------
interface apb_req_arbiter_if #(
  parameter int ADDR_W = apb_ctrl_pkg::DEF_ADDR_W,
  parameter int DATA_W = apb_ctrl_pkg::DEF_DATA_W
) ();
  import apb_ctrl_pkg::*;

  // requester side
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ack;
  logic [1:0]          req_done;
  logic                req_err;
  logic [DATA_W-1:0]   req_rdata;

  // bridge control
  logic                transfer;
  logic                READ_WRITE;
  logic [ADDR_W-1:0]   apb_write_paddr;
  logic [ADDR_W-1:0]   apb_read_paddr;
  logic [DATA_W-1:0]   apb_write_data;

  // monitored APB bus
  logic                PENABLE;
  logic                PREADY;
  logic                PSLVERR;
  logic [DATA_W-1:0]   PRDATA;

  logic                busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  PENABLE, PREADY, PSLVERR, PRDATA,
    output req_ack, req_done, req_err, req_rdata,
    output transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
    output busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output PENABLE, PREADY, PSLVERR, PRDATA,
    input  req_ack, req_done, req_err, req_rdata,
    input  transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
    input  busy
  );

endinterface

// File: rtl/apb_req_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector, bit i = requester i
//   update   : strobe; the current grant is being taken, remember it
//   gnt      : one-hot grant (combinational from req and last-grant)
// A single request always wins. On contention the requester that was not
// granted last wins. Last-grant resets to 1 so requester 0 wins the first
// contention.
// -----------------------------------------------------------------------------
module rr_arb2
  import apb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = idx2oh(~last_q);
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (update && (|gnt)) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
// Arbitrates two requesters onto one APB master bridge and tracks the bus
// transfer through SETUP and ACCESS, aborting on a bounded number of wait
// states.
//   PCLK, PRESET : clock, asynchronous active-high reset
//   bus (slave)  : requester handshake (req_valid/write/addr/wdata in,
//                  req_ack/done/err/rdata out), bridge controls (transfer,
//                  READ_WRITE, apb_write_paddr, apb_read_paddr,
//                  apb_write_data), monitored APB signals (PENABLE, PREADY,
//                  PSLVERR, PRDATA) and busy.
// Parameters: ADDR_W, DATA_W, TIMEOUT (ACCESS cycles before abort, 2..255).
// Every output is a flop; next-output values are derived from the next state
// so outputs line up with the state they belong to.
// -----------------------------------------------------------------------------
module apb_req_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_req_arbiter_if.slave bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Read data reported at completion. A read keeps the previous value unless
  // PRDATA was actually captured; an errored write clears it.
  function automatic logic [DATA_W-1:0] done_rdata(
    input logic              is_read,
    input logic              captured,
    input logic              err,
    input logic [DATA_W-1:0] prdata,
    input logic [DATA_W-1:0] held
  );
    if (is_read) begin
      return captured ? prdata : held;
    end
    return err ? '0 : held;
  endfunction

  state_e            state_q, state_d;
  logic              gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              transfer_q, transfer_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;

  logic [1:0]        arb_gnt;
  logic              arb_update;
  logic              gnt_sel;
  logic              write_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              is_read;

  // The arbiter only advances its history when a grant is actually taken.
  assign arb_update = (state_q == ST_IDLE) && (|bus.req_valid);

  rr_arb2 u_rr_arb2 (
    .clk    (PCLK),
    .rst    (PRESET),
    .req    (bus.req_valid),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  always_comb begin
    gnt_sel   = arb_gnt[1];
    write_sel = gnt_sel ? bus.req_write[1] : bus.req_write[0];
    addr_sel  = gnt_sel ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
    wdata_sel = gnt_sel ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
  end

  assign is_read = (rw_q == DIR_READ);

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    cnt_d      = cnt_q;
    transfer_d = transfer_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ack_d      = 2'b00;
    done_d     = 2'b00;
    err_d      = 1'b0;
    rdata_d    = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          gnt_idx_d  = gnt_sel;
          rw_d       = write_sel ? DIR_WRITE : DIR_READ;
          addr_d     = addr_sel;
          wdata_d    = write_sel ? wdata_sel : '0;
          ack_d      = arb_gnt;
          transfer_d = 1'b1;
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        // A slave error while still in setup aborts before ACCESS.
        if (bus.PSLVERR) begin
          state_d    = ST_DONE;
          transfer_d = 1'b0;
          done_d     = idx2oh(gnt_idx_q);
          err_d      = 1'b1;
          rdata_d    = done_rdata(is_read, 1'b0, 1'b1, bus.PRDATA, rdata_q);
        end else if (bus.PENABLE) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
        end
      end

      ST_ACCESS: begin
        // Completion is checked first so it wins over the terminal count.
        if (bus.PENABLE && bus.PREADY) begin
          state_d    = ST_DONE;
          transfer_d = 1'b0;
          done_d     = idx2oh(gnt_idx_q);
          err_d      = bus.PSLVERR;
          rdata_d    = done_rdata(is_read, 1'b1, bus.PSLVERR, bus.PRDATA, rdata_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_DONE;
          transfer_d = 1'b0;
          done_d     = idx2oh(gnt_idx_q);
          err_d      = 1'b1;
          rdata_d    = done_rdata(is_read, 1'b0, 1'b1, bus.PRDATA, rdata_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        transfer_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= 1'b0;
      cnt_q      <= '0;
      transfer_q <= 1'b0;
      rw_q       <= DIR_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      cnt_q      <= cnt_d;
      transfer_q <= transfer_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.transfer        = transfer_q;
  assign bus.READ_WRITE      = rw_q;
  assign bus.apb_write_paddr = addr_q;
  assign bus.apb_read_paddr  = addr_q;
  assign bus.apb_write_data  = wdata_q;
  assign bus.req_ack         = ack_q;
  assign bus.req_done        = done_q;
  assign bus.req_err         = err_q;
  assign bus.req_rdata       = rdata_q;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_req_arbiter
// Self-checking bench for apb_req_arbiter: directed vector table, a mid-
// transaction reset sequence, then randomized transactions whose expectations
// come from a transaction-level model (round-robin pick, wait-state count vs.
// timeout budget, read-data hold rules).
// The bridge is modelled by driving PENABLE from transfer and PREADY/PSLVERR
// from a per-transaction wait-state count.
// -----------------------------------------------------------------------------
module tb_apb_req_arbiter;
  import apb_ctrl_pkg::*;

  localparam int AW  = 9;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic PCLK = 1'b0;
  logic PRESET;

  apb_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (ifc.slave)
  );

  always #5 PCLK = ~PCLK;

  assign ifc.PENABLE = ifc.transfer;

  typedef struct packed {
    logic [1:0]    valid;
    logic [1:0]    wr;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    int            waits;
    bit            perr;
    bit            serr;
    logic [DW-1:0] prd;
    bit            hold;
    int            e_gnt;
    bit            e_err;
    logic [DW-1:0] e_rd;
    int            e_xf;
  } vec_t;

  vec_t tbl [12];

  int checks = 0;
  int errors = 0;

  int            m_last  = 1;
  logic [DW-1:0] m_rdata = '0;

  function automatic vec_t mk(
    input logic [1:0] valid, input logic [1:0] wr,
    input logic [AW-1:0] a0, input logic [AW-1:0] a1,
    input logic [DW-1:0] d0, input logic [DW-1:0] d1,
    input int waits, input bit perr, input bit serr,
    input logic [DW-1:0] prd, input bit hold,
    input int e_gnt, input bit e_err, input logic [DW-1:0] e_rd, input int e_xf);
    vec_t v;
    v.valid = valid; v.wr = wr; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.waits = waits; v.perr = perr; v.serr = serr; v.prd = prd; v.hold = hold;
    v.e_gnt = e_gnt; v.e_err = e_err; v.e_rd = e_rd; v.e_xf = e_xf;
    return v;
  endfunction

  // Transaction-level reference: who wins, how many transfer-high cycles,
  // what error and read data the requester sees.
  function automatic vec_t model(input vec_t vin);
    vec_t v;
    int   g;
    bit   rd;
    v = vin;
    if (v.valid == 2'b01)      g = 0;
    else if (v.valid == 2'b10) g = 1;
    else                       g = 1 - m_last;
    rd = !v.wr[g];
    v.e_gnt = g;
    if (v.serr) begin
      v.e_xf  = 1;
      v.e_err = 1'b1;
      v.e_rd  = rd ? m_rdata : '0;
    end else if (v.waits + 1 <= TMO) begin
      v.e_xf  = v.waits + 2;
      v.e_err = v.perr;
      v.e_rd  = rd ? v.prd : (v.perr ? '0 : m_rdata);
    end else begin
      v.e_xf  = 1 + TMO;
      v.e_err = 1'b1;
      v.e_rd  = rd ? m_rdata : '0;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_transfer"},   32'(ifc.transfer), 0);
    chk({tag, "_read_write"}, 32'(ifc.READ_WRITE), 1);
    chk({tag, "_wpaddr"},     32'(ifc.apb_write_paddr), 0);
    chk({tag, "_rpaddr"},     32'(ifc.apb_read_paddr), 0);
    chk({tag, "_wdata"},      32'(ifc.apb_write_data), 0);
    chk({tag, "_ack"},        32'(ifc.req_ack), 0);
    chk({tag, "_done"},       32'(ifc.req_done), 0);
    chk({tag, "_err"},        32'(ifc.req_err), 0);
    chk({tag, "_rdata"},      32'(ifc.req_rdata), 0);
    chk({tag, "_busy"},       32'(ifc.busy), 0);
  endtask

  // c = 1 is the SETUP cycle, c = k+1 is ACCESS cycle k.
  task automatic drive_bridge(input int c, input vec_t v);
    ifc.PREADY  = !v.serr && (c == v.waits + 2);
    ifc.PSLVERR = v.serr ? (c == 1) : (v.perr && (c == v.waits + 2));
    ifc.PRDATA  = v.prd;
  endtask

  task automatic run_vec(input vec_t v, input bit garble);
    int            lat;
    int            c;
    bit            ok;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          erw;
    logic [1:0]    eoh;
    ea  = (v.e_gnt == 1) ? v.a1 : v.a0;
    erw = !v.wr[v.e_gnt];
    ed  = erw ? '0 : ((v.e_gnt == 1) ? v.d1 : v.d0);
    eoh = (v.e_gnt == 1) ? 2'b10 : 2'b01;

    ifc.req_valid = v.valid;
    ifc.req_write = v.wr;
    ifc.req_addr  = {v.a1, v.a0};
    ifc.req_wdata = {v.d1, v.d0};

    lat = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      lat++;
      if (ifc.req_ack != 2'b00) break;
    end
    chk("ack", 32'(ifc.req_ack), 32'(eoh));
    chk("ack_latency", lat, 1);
    chk("read_write", 32'(ifc.READ_WRITE), 32'(erw));
    chk("wpaddr", 32'(ifc.apb_write_paddr), 32'(ea));
    chk("rpaddr", 32'(ifc.apb_read_paddr), 32'(ea));
    chk("wdata", 32'(ifc.apb_write_data), 32'(ed));

    if (!v.hold) begin
      ifc.req_valid = garble ? 2'($urandom) : 2'b00;
    end
    drive_bridge(1, v);
    c  = 1;
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (!ifc.transfer) break;
      c++;
      if (ifc.apb_write_paddr !== ea || ifc.apb_read_paddr !== ea ||
          ifc.apb_write_data !== ed || ifc.READ_WRITE !== erw ||
          ifc.req_ack !== 2'b00 || ifc.req_done !== 2'b00 || ifc.busy !== 1'b1)
        ok = 1'b0;
      if (garble) begin
        ifc.req_valid = 2'($urandom);
        ifc.req_write = 2'($urandom);
        ifc.req_addr  = (2*AW)'($urandom);
        ifc.req_wdata = (2*DW)'($urandom);
      end
      drive_bridge(c, v);
    end
    chk("hold_stable", 32'(ok), 1);
    chk("xfer_cycles", c, v.e_xf);
    chk("transfer_in_done", 32'(ifc.transfer), 0);
    chk("done", 32'(ifc.req_done), 32'(eoh));
    chk("err", 32'(ifc.req_err), 32'(v.e_err));
    chk("rdata", 32'(ifc.req_rdata), 32'(v.e_rd));

    ifc.PREADY  = 1'b0;
    ifc.PSLVERR = 1'b0;
    if (!v.hold) ifc.req_valid = 2'b00;
    @(negedge PCLK);
    chk("done_pulse_end", 32'(ifc.req_done), 0);
    chk("idle_busy", 32'(ifc.busy), 0);

    m_last  = v.e_gnt;
    m_rdata = v.e_rd;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   dn;

    //           valid  wr     a0      a1      d0     d1     wt pe se prd    hd  g er rd     xf
    tbl[0]  = mk(2'b01, 2'b01, 9'h012, 9'h000, 8'hA5, 8'h00, 0, 0, 0, 8'h00, 0,  0, 0, 8'h00, 2);
    tbl[1]  = mk(2'b10, 2'b00, 9'h000, 9'h1F0, 8'h00, 8'h00, 3, 0, 0, 8'h3C, 0,  1, 0, 8'h3C, 5);
    tbl[2]  = mk(2'b11, 2'b01, 9'h055, 9'h0AA, 8'h11, 8'h22, 1, 0, 0, 8'h77, 1,  0, 0, 8'h3C, 3);
    tbl[3]  = mk(2'b11, 2'b01, 9'h055, 9'h0AA, 8'h11, 8'h22, 1, 0, 0, 8'h77, 1,  1, 0, 8'h77, 3);
    tbl[4]  = mk(2'b11, 2'b01, 9'h055, 9'h0AA, 8'h11, 8'h22, 1, 0, 0, 8'h66, 1,  0, 0, 8'h77, 3);
    tbl[5]  = mk(2'b11, 2'b01, 9'h055, 9'h0AA, 8'h11, 8'h22, 1, 0, 0, 8'h78, 0,  1, 0, 8'h78, 3);
    tbl[6]  = mk(2'b01, 2'b00, 9'h100, 9'h000, 8'h00, 8'h00, 99, 0, 0, 8'hEE, 0, 0, 1, 8'h78, 17);
    tbl[7]  = mk(2'b10, 2'b10, 9'h000, 9'h0F0, 8'h00, 8'hC3, 0, 0, 1, 8'h00, 0,  1, 1, 8'h00, 1);
    tbl[8]  = mk(2'b01, 2'b00, 9'h1AB, 9'h000, 8'h00, 8'h00, 15, 0, 0, 8'h5A, 0, 0, 0, 8'h5A, 17);
    tbl[9]  = mk(2'b10, 2'b10, 9'h000, 9'h033, 8'h00, 8'h44, 2, 1, 0, 8'h00, 0,  1, 1, 8'h00, 4);
    tbl[10] = mk(2'b01, 2'b00, 9'h077, 9'h000, 8'h00, 8'h00, 0, 1, 0, 8'h99, 0,  0, 1, 8'h99, 2);
    tbl[11] = mk(2'b11, 2'b11, 9'h001, 9'h002, 8'h01, 8'h02, 20, 0, 0, 8'h00, 0, 1, 1, 8'h00, 17);

    ifc.req_valid = '0;
    ifc.req_write = '0;
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;
    ifc.PREADY    = 1'b0;
    ifc.PSLVERR   = 1'b0;
    ifc.PRDATA    = '0;
    PRESET        = 1'b1;
    repeat (2) @(negedge PCLK);
    check_reset("rst_init");
    PRESET = 1'b0;

    // nothing requested: stays idle
    repeat (2) @(negedge PCLK);
    chk("idle_no_ack", 32'(ifc.req_ack), 0);
    chk("idle_no_busy", 32'(ifc.busy), 0);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'b0);

    // reset in the middle of an ACCESS wait
    ifc.req_valid = 2'b01;
    ifc.req_write = 2'b00;
    ifc.req_addr  = {9'h000, 9'h0C5};
    ifc.PREADY    = 1'b0;
    @(negedge PCLK);
    chk("rst_pre_ack", 32'(ifc.req_ack), 1);
    ifc.req_valid = 2'b00;
    repeat (4) @(negedge PCLK);
    chk("rst_pre_busy", 32'(ifc.busy), 1);
    #2 PRESET = 1'b1;
    #1 check_reset("rst_mid");
    @(negedge PCLK);
    PRESET  = 1'b0;
    m_last  = 1;
    m_rdata = '0;
    dn = 0;
    repeat (3) begin
      @(negedge PCLK);
      if (ifc.req_done != 2'b00) dn++;
    end
    chk("rst_no_done", dn, 0);
    // last grant was requester 0 before reset; reset must make 0 win again
    v = model(mk(2'b11, 2'b10, 9'h0D1, 9'h0D2, 8'h00, 8'hB7, 1, 0, 0, 8'h42, 0, 0, 0, 0, 0));
    chk("rst_model_gnt", v.e_gnt, 0);
    run_vec(v, 1'b0);

    for (int i = 0; i < 40; i++) begin
      v.valid = 2'($urandom_range(1, 3));
      v.wr    = 2'($urandom);
      v.a0    = AW'($urandom);
      v.a1    = AW'($urandom);
      v.d0    = DW'($urandom);
      v.d1    = DW'($urandom);
      v.waits = $urandom_range(0, 17);
      v.perr  = ($urandom_range(0, 7) == 0);
      v.serr  = ($urandom_range(0, 9) == 0);
      v.prd   = DW'($urandom);
      v.hold  = ($urandom_range(0, 3) == 0);
      v = model(v);
      run_vec(v, !v.hold && ($urandom_range(0, 1) == 1));
    end
    ifc.req_valid = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
